// File: rtl/dds_sweep_track_ctrl_if.sv
// Programming/control bundle between the carrier-recovery loop and the DDS increment controller.
// The master side drives config and loop inputs; the slave (controller) drives the DDS bus.
interface dds_sweep_track_ctrl_if #(
  parameter int unsigned W = 24
);
  logic         start;
  logic         stop;
  logic [W-1:0] cfg_center;
  logic [W-1:0] cfg_span;
  logic [W-1:0] cfg_step;
  logic         lock;
  logic         corr_valid;
  logic [W-1:0] corr;
  logic [W-1:0] dds_data;
  logic         dds_we;
  logic [4:0]   dds_addr;
  logic         dds_ce;
  logic [1:0]   state;
  logic [W-1:0] cur_inc;

  modport master (
    output start, stop, cfg_center, cfg_span, cfg_step, lock, corr_valid, corr,
    input  dds_data, dds_we, dds_addr, dds_ce, state, cur_inc
  );

  modport slave (
    input  start, stop, cfg_center, cfg_span, cfg_step, lock, corr_valid, corr,
    output dds_data, dds_we, dds_addr, dds_ce, state, cur_inc
  );
endinterface

// File: rtl/dds_sweep_track_ctrl.sv
// DDS phase-increment controller: stepped sweep inside [lo,hi] until lock, then
// centre+correction tracking, falling back to the sweep after a sustained loss of lock.
module dds_sweep_track_ctrl #(
  parameter int unsigned W        = 24,
  parameter int unsigned DWELL    = 1024,
  parameter int unsigned LOSS_CNT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  dds_sweep_track_ctrl_if.slave   bus_io
);

  localparam int unsigned DwW   = $clog2(DWELL);
  localparam int unsigned LossW = $clog2(LOSS_CNT + 1);
  localparam logic [DwW-1:0]   DwellLast = DwW'(DWELL - 1);
  localparam logic [LossW-1:0] LossLast  = LossW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {StIdle = 2'd0, StSweep = 2'd1, StTrack = 2'd2} state_e;

  state_e           state_q;
  logic [W-1:0]     inc_q;
  logic             we_q;
  logic             ce_q;
  logic [DwW-1:0]   dwell_q;
  logic [LossW-1:0] loss_q;

  logic [W:0]   lo_diff, hi_sum, step_sum;
  logic [W+1:0] trk_sum;
  logic [W-1:0] lo, hi, step_next, trk_val;

  always_comb begin
    lo_diff = {1'b0, bus_io.cfg_center} - {1'b0, bus_io.cfg_span};
    hi_sum  = {1'b0, bus_io.cfg_center} + {1'b0, bus_io.cfg_span};
    // Borrow out of the subtraction means center < span: clamp to zero.
    lo = lo_diff[W] ? '0 : lo_diff[W-1:0];
    hi = hi_sum[W] ? '1 : hi_sum[W-1:0];

    step_sum  = {1'b0, inc_q} + {1'b0, bus_io.cfg_step};
    step_next = (step_sum > {1'b0, hi}) ? lo : step_sum[W-1:0];

    // Signed W+2 sum; the top bit set means a negative result.
    trk_sum = {2'b00, bus_io.cfg_center} + {{2{bus_io.corr[W-1]}}, bus_io.corr};
    if (trk_sum[W+1] || (trk_sum[W:0] < {1'b0, lo})) begin
      trk_val = lo;
    end else if (trk_sum[W:0] > {1'b0, hi}) begin
      trk_val = hi;
    end else begin
      trk_val = trk_sum[W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      inc_q   <= '0;
      we_q    <= 1'b0;
      ce_q    <= 1'b0;
      dwell_q <= '0;
      loss_q  <= '0;
    end else begin
      ce_q <= 1'b1;
      we_q <= 1'b0;
      if (bus_io.stop) begin
        state_q <= StIdle;
      end else if (bus_io.start) begin
        inc_q   <= lo;
        we_q    <= 1'b1;
        dwell_q <= '0;
        state_q <= StSweep;
      end else begin
        case (state_q)
          StSweep: begin
            if (bus_io.lock) begin
              state_q <= StTrack;
              loss_q  <= '0;
            end else if (dwell_q == DwellLast) begin
              inc_q   <= step_next;
              we_q    <= 1'b1;
              dwell_q <= '0;
            end else begin
              dwell_q <= dwell_q + 1'b1;
            end
          end
          StTrack: begin
            if (bus_io.corr_valid) begin
              inc_q <= trk_val;
              we_q  <= 1'b1;
            end
            if (bus_io.lock) begin
              loss_q <= '0;
            end else if (loss_q == LossLast) begin
              loss_q  <= '0;
              dwell_q <= '0;
              state_q <= StSweep;
            end else begin
              loss_q <= loss_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus_io.dds_data = inc_q;
  assign bus_io.cur_inc  = inc_q;
  assign bus_io.dds_we   = we_q;
  assign bus_io.dds_ce   = ce_q;
  assign bus_io.dds_addr = 5'd0;
  assign bus_io.state    = state_q;

endmodule

// File: doc/dds_sweep_track_ctrl.md
Name: dds_sweep_track_ctrl

Overview:
- Frequency controller for the carrier-recovery DDS (24-bit phase-increment input with DATA/WE/A/CE programming interface, 16-bit SINE/COSINE outputs).
- Sequences acquisition as a stepped frequency sweep around a configured centre until the lock detector asserts.
- Then tracks by writing centre+correction from the loop filter.
- Sits between the loop filter / lock detector and the DDS core, and is the sole writer of the DDS increment.

Parameters:
- W, 24, phase-increment width (matches DDS DATA).
- DWELL, 1024, clock cycles per sweep step (>=2).
- LOSS_CNT, 16, consecutive lock-low cycles in TRACK before returning to SWEEP (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin acquisition
- stop  in  1  pulse: return to IDLE
- cfg_center  in  W  nominal phase increment (unsigned)
- cfg_span  in  W  half-width of sweep/track window (unsigned)
- cfg_step  in  W  sweep increment per dwell (unsigned, nonzero)
- lock  in  1  lock-detector flag
- corr_valid  in  1  loop-filter output strobe
- corr  in  W  loop-filter correction, two's complement
- dds_data  out  W  DDS DATA
- dds_we  out  1  DDS WE, one-cycle pulse
- dds_addr  out  5  DDS A, constant 0
- dds_ce  out  1  DDS CE
- state  out  2  0=IDLE 1=SWEEP 2=TRACK
- cur_inc  out  W  increment most recently written

Behaviour:
- Reset (async, active-high): state=IDLE; dds_data=0, dds_we=0, dds_addr=0, dds_ce=0, cur_inc=0; dwell and loss counters cleared. All outputs registered.
- dds_ce: 0 in reset, 1 from the first clock edge after reset deassertion onward, in every state.
- Window bounds, recomputed combinationally from cfg each cycle using W+1-bit arithmetic:
  - lo = max(center-span, 0)
  - hi = min(center+span, 2^W-1)
- Write rule: every write sets dds_data=cur_inc=value and pulses dds_we for exactly one cycle. At most one write per cycle. dds_data holds its value between writes.
- IDLE:
  - start=1 -> write lo, dwell counter=0, go SWEEP (dds_we high the cycle after start).
  - All other inputs ignored.
- SWEEP:
  - Dwell counter increments each cycle.
  - At count DWELL-1: next = cur_inc+step. If next > hi (including W-bit carry), next = lo (wrap). Write next, counter=0.
  - lock=1 -> go TRACK next cycle, no step write that cycle. lock takes priority over a simultaneous dwell expiry. Loss counter=0.
  - corr_valid ignored.
- TRACK:
  - corr_valid=1 -> v = center + sign-extended corr, in W+2 bits, clamped to [lo,hi]. Write v on the next edge (latency 1 cycle from corr_valid to dds_we).
  - lock=0 increments the loss counter; lock=1 clears it.
  - Loss counter reaching LOSS_CNT -> go SWEEP, dwell counter=0. Sweep resumes from the current cur_inc; no immediate write.
  - A corr_valid in the same cycle as loss expiry is still written.
- stop=1 in any state -> IDLE next cycle, no write; dds_data/cur_inc hold. stop beats a simultaneous start or lock.
- start while in SWEEP/TRACK: restart acquisition, i.e. write lo and enter SWEEP.
- cfg changes mid-operation take effect on the next computed write; no retroactive write.
- span=0: lo=hi=center; sweep rewrites center every DWELL cycles.
- Reset mid-operation: immediate return to reset values. The DDS retains its last programmed value, but dds_ce=0 halts it.

Test Plan:
- Reset/idle: assert reset mid-SWEEP -> all outputs 0 asynchronously; after release dds_ce=1, state=0, no dds_we.
- Sweep wrap: center=0x100000, span=0x000400, step=0x000300, DWELL=8, start -> writes 0x0FFC00, 0x0FFF00, 0x100200, then wrap to 0x0FFC00, spaced exactly 8 cycles, each dds_we one cycle wide, dds_addr=0.
- Acquire/track: lock=1 on a dwell-expiry cycle -> no step write, state=2. Then corr_valid with corr=-0x000100 -> next cycle dds_data=0x0FFF00, dds_we=1.
- Clamp: in TRACK, corr=+0x7FFFFF -> dds_data=hi=0x100400. Separately, center=0x000010, span=0x20, start -> first write 0x000000 (lo clamped at 0).
- Loss of lock: LOSS_CNT=16; lock low 15 cycles, high 1, low 16 -> SWEEP entered only after the final 16-cycle run, and the next step is taken from cur_inc.
- Priority: start and stop asserted together in IDLE -> stays IDLE, no write. stop during TRACK with corr_valid -> IDLE, no write.
